// File: rtl/sv32_tlb_refill_walker.sv
// sv32_tlb_refill_walker
//
// Hardware page-table walker that refills an Sv32 TLB after a miss. A miss
// is accepted in IDLE. The walker reads the level-1 PTE and, for a non-leaf
// PTE, the level-0 PTE. It then spends one DONE cycle presenting either a TLB
// update or a page-fault pulse.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   miss_valid_i/ready  miss request handshake (ready only in IDLE)
//   miss_vaddr_i        faulting virtual address
//   miss_asid_i         ASID of the miss
//   satp_ppn_i          root page-table PPN, sampled when the miss is accepted
//   mem_req_valid_o     PTE read request
//   mem_req_ready_i     PTE read request accept
//   mem_req_addr_o      34-bit physical address of the PTE
//   mem_rsp_valid_i     PTE read response strobe
//   mem_rsp_data_i      PTE read response data
//   flush_i             abort the current walk
//   update_o            {valid, is_4M, vpn[19:0], asid, pte[31:0]}; zero unless valid
//   fault_o             one-cycle page-fault pulse
//   fault_vaddr_o       faulting virtual address while fault_o is high, else zero
//   busy_o              high in every state except IDLE
//   dbg_state_o         current FSM state encoding
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. Once valid is raised it stays high, and its payload stays
// stable, until that transfer. Responses have no ready: the walker keeps at
// most one request outstanding and is always able to take its response.
module sv32_tlb_refill_walker #(
  parameter int ASID_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_valid_i,
  output logic                     miss_ready_o,
  input  logic [31:0]              miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0]    miss_asid_i,
  input  logic [21:0]              satp_ppn_i,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [33:0]              mem_req_addr_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [31:0]              mem_rsp_data_i,
  input  logic                     flush_i,
  output logic [54+ASID_WIDTH-1:0] update_o,
  output logic                     fault_o,
  output logic [31:0]              fault_vaddr_o,
  output logic                     busy_o,
  output logic [2:0]               dbg_state_o
);

  localparam int UPD_W = 54 + ASID_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_DONE    = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           vaddr_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic [21:0]           satp_q;
  // Holds the non-leaf L1 PTE while walking L0, then the final leaf PTE.
  logic [31:0]           pte_q;
  logic                  ok_q;
  logic                  is_4m_q;

  // Decode of the PTE in the response. Bits: V=0, R=1, W=2, X=3.
  logic pte_bad;
  logic pte_leaf;
  logic pte_misaligned;
  logic emit;
  logic upd_valid;

  assign pte_bad        = !mem_rsp_data_i[0] || (!mem_rsp_data_i[1] && mem_rsp_data_i[2]);
  assign pte_leaf       = mem_rsp_data_i[1] || mem_rsp_data_i[3];
  // A superpage leaf must have PPN[0] == 0.
  assign pte_misaligned = (mem_rsp_data_i[19:10] != 10'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vaddr_q <= '0;
      asid_q  <= '0;
      satp_q  <= '0;
      pte_q   <= '0;
      ok_q    <= 1'b0;
      is_4m_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && miss_valid_i) begin
        vaddr_q <= miss_vaddr_i;
        asid_q  <= miss_asid_i;
        satp_q  <= satp_ppn_i;
      end
      if (state_q == S_L1_WAIT && mem_rsp_valid_i) begin
        pte_q   <= mem_rsp_data_i;
        ok_q    <= !pte_bad && pte_leaf && !pte_misaligned;
        is_4m_q <= 1'b1;
      end
      if (state_q == S_L0_WAIT && mem_rsp_valid_i) begin
        pte_q   <= mem_rsp_data_i;
        ok_q    <= !pte_bad && pte_leaf;
        is_4m_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss_valid_i) state_d = S_L1_REQ;
      end
      S_L1_REQ: begin
        // If the request is accepted in the same cycle as a flush, its
        // response must still be absorbed.
        if (mem_req_ready_i) state_d = flush_i ? S_DRAIN : S_L1_WAIT;
        else if (flush_i)    state_d = S_IDLE;
      end
      S_L1_WAIT: begin
        if (mem_rsp_valid_i) begin
          if (flush_i)                   state_d = S_IDLE;
          else if (pte_bad || pte_leaf)  state_d = S_DONE;
          else                           state_d = S_L0_REQ;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_L0_REQ: begin
        if (mem_req_ready_i) state_d = flush_i ? S_DRAIN : S_L0_WAIT;
        else if (flush_i)    state_d = S_IDLE;
      end
      S_L0_WAIT: begin
        if (mem_rsp_valid_i) state_d = flush_i ? S_IDLE : S_DONE;
        else if (flush_i)    state_d = S_DRAIN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    case (state_q)
      S_L1_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {satp_q, vaddr_q[31:22], 2'b00};
      end
      S_L0_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {pte_q[31:10], vaddr_q[21:12], 2'b00};
      end
      default: begin
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
      end
    endcase
  end

  // A flush during DONE cancels the result that would otherwise be presented.
  assign emit          = (state_q == S_DONE) && !flush_i;
  assign upd_valid     = emit && ok_q;
  assign fault_o       = emit && !ok_q;
  assign fault_vaddr_o = fault_o ? vaddr_q : 32'd0;
  assign update_o      = upd_valid ? {1'b1, is_4m_q, vaddr_q[31:12], asid_q, pte_q}
                                   : {UPD_W{1'b0}};
  assign miss_ready_o  = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: doc/sv32_tlb_refill_walker.md
SV32_TLB_REFILL_WALKER -- requirements
Module: sv32_tlb_refill_walker

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 9, which sets the ASID width; UPD_W = 54+ASID_WIDTH.
REQ-002 SHALL have clk, input, 1: clock; reset reset, synchronous, active-high; clock clk.
REQ-003 SHALL have reset, input, 1: synchronous active-high reset.
REQ-004 SHALL have miss_valid_i / miss_ready_o, in/out, 1/1: TLB-miss request handshake.
REQ-005 SHALL have miss_vaddr_i, in, 32, and miss_asid_i, in, ASID_WIDTH: the missing address and its ASID.
REQ-006 SHALL have satp_ppn_i, in, 22: root page-table PPN, sampled at miss acceptance.
REQ-007 SHALL have mem_req_valid_o / mem_req_ready_i, out/in, 1/1, and mem_req_addr_o, out, 34: PTE read request.
REQ-008 SHALL have mem_rsp_valid_i, in, 1, and mem_rsp_data_i, in, 32: PTE read response.
REQ-009 SHALL have flush_i, in, 1: abort the current walk.
REQ-010 SHALL have update_o, out, UPD_W: TLB update packed as {valid, is_4M, vpn[19:0], asid, content[31:0]}.
REQ-011 SHALL have fault_o, out, 1 (one-cycle page-fault pulse), fault_vaddr_o, out, 32, and busy_o, out, 1.

Function
REQ-012 FSM states: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN.
REQ-013 IDLE: miss_ready_o=1; when miss_valid_i=1, SHALL latch vaddr, asid and satp_ppn and go to L1_REQ; miss_ready_o=0 in all other states.
REQ-014 L1_REQ: mem_req_valid_o=1 and mem_req_addr_o={satp_ppn,vaddr[31:22],2'b00}, held stable until mem_req_ready_i=1, then go to L1_WAIT.
REQ-015 L1_WAIT, on mem_rsp_valid_i, classify the PTE as follows:
- V=0, or R=0 with W=1: fault, go to DONE.
- Leaf (R|X) with pte[19:10]!=0: misaligned-superpage fault, go to DONE.
- Leaf otherwise: success with is_4M=1, go to DONE.
- Non-leaf: go to L0_REQ.
REQ-016 L0_REQ: mem_req_addr_o={pte[31:10],vaddr[21:12],2'b00}; handshake as in L1_REQ, then go to L0_WAIT.
REQ-017 L0_WAIT, on response: invalid PTE, R=0 with W=1, or non-leaf is a fault; otherwise success with is_4M=0; go to DONE in every case.
REQ-018 DONE lasts exactly one cycle and then goes to IDLE.
- On success: update_o.valid=1, vpn=vaddr[31:12], asid=latched asid, content=the leaf PTE unchanged.
- On fault: fault_o=1 and fault_vaddr_o=vaddr.
REQ-019 update_o.valid and fault_o SHALL be 0 outside DONE and SHALL never both be 1.
REQ-020 Zero-wait latency (miss accepted in cycle 0): superpage update in cycle 3; 4 KiB update in cycle 5.
REQ-021 At most one memory request SHALL be outstanding; mem_rsp_valid_i SHALL be ignored outside L1_WAIT, L0_WAIT and DRAIN.
REQ-022 flush_i in IDLE: no effect.
REQ-023 flush_i in L1_REQ or L0_REQ: go to IDLE next cycle; a request accepted in the same cycle as the flush goes to DRAIN instead.
REQ-024 flush_i in L1_WAIT or L0_WAIT, with no response in that cycle: go to DRAIN; with a response in that cycle: discard it and go to IDLE.
REQ-025 DRAIN: discard the next response, then go to IDLE.
REQ-026 flush_i in DONE: suppress both update_o.valid and fault_o.
REQ-027 busy_o=1 in every state except IDLE.

Reset
REQ-028 On reset: state=IDLE; update_o=0; fault_o=0; fault_vaddr_o=0; mem_req_valid_o=0; busy_o=0; miss_ready_o=1 in the first cycle after reset deasserts.
REQ-029 Reset mid-walk SHALL abandon the walk; no update or fault is emitted, and a late response after reset is ignored.

Verification
REQ-030 Common setup for REQ-031 to REQ-034: satp_ppn=0x00080, vaddr=0x12345678, asid=0x005.
REQ-031 4 KiB walk:
- L1 read at addr 0x080120 returns PTE 0x20000001 (non-leaf).
- L0 read at addr 0x80000D14 returns PTE 0x123450CF.
- Required: update_o = {1,0,0x12345,0x005,0x123450CF} for one cycle.
REQ-032 Superpage walk: L1 returns PTE 0x200000CF -> update with is_4M=1, content 0x200000CF, and no L0 request is issued.
REQ-033 Faults:
- L1 returns 0x200004CF -> fault_o pulse with fault_vaddr_o=0x12345678.
- L1 returns 0x00000000 -> fault_o pulse.
- L0 returns 0x20000001 (non-leaf) -> fault_o pulse.
REQ-034 flush_i asserted in L1_WAIT, response arrives 2 cycles later -> no update and no fault; miss_ready_o=1 the cycle after the response.
REQ-035 mem_req_ready_i held at 0 for 5 cycles -> mem_req_valid_o and mem_req_addr_o stay stable; reset asserted in L0_WAIT -> IDLE and no update_o.valid.
